tx_lane_symbol_gen: RTL and testbench



---
 rtl/aurora_pkg.sv | 32 +++
 rtl/tx_lane_symbol_gen.sv | 140 ++++++++++++++
 tb/tb_tx_lane_symbol_gen.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/aurora_pkg.sv
// Shared types and 8B/10B symbol constants for the Aurora lane transmit path.
package aurora_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SCP2 = 3'd1,
        ST_DATA = 3'd2,
        ST_ECP1 = 3'd3,
        ST_ECP2 = 3'd4
    } tx_state_t;

    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K28_3 = 8'h7C;
    localparam logic [7:0] K28_0 = 8'h1C;
    localparam logic [7:0] K28_2 = 8'h5C;
    localparam logic [7:0] K27_7 = 8'hFB;
    localparam logic [7:0] K29_7 = 8'hFD;
    localparam logic [7:0] K30_7 = 8'hFE;

    // Idle selection: A beats R beats K; with no flag the lane still sends K28.5.
    function automatic logic [7:0] idle_symbol(input logic a, input logic r, input logic k);
        logic [7:0] sym;
        casez ({a, r, k})
            3'b1??:  sym = K28_3;
            3'b01?:  sym = K28_0;
            3'b001:  sym = K28_5;
            default: sym = K28_5;
        endcase
        return sym;
    endfunction

endpackage

// File: rtl/tx_lane_symbol_gen.sv
// Lane TX symbol generator: frames user bytes with SCP/ECP and fills gaps with idles.
module tx_lane_symbol_gen
    import aurora_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       channel_up,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_sof,
    input  logic       tx_eof,
    output logic       tx_ready,
    output logic       send_idle,
    input  logic       send_K,
    input  logic       send_A,
    input  logic       send_R,
    output logic [7:0] enc_data,
    output logic       enc_is_k,
    output logic       protocol_err
);

    tx_state_t  r_state;
    logic       r_first;
    logic [7:0] r_enc_data;
    logic       r_enc_is_k;
    logic       r_protocol_err;

    logic       w_tx_ready;
    logic       w_send_idle;
    logic       w_accept;
    tx_state_t  w_next_state;
    logic       w_first_next;
    logic [7:0] w_sym;
    logic       w_is_k;
    logic       w_err;

    // Handshake and idle request depend only on state and user-side inputs (no loop via send_K/A/R).
    always_comb begin
        w_tx_ready  = 1'b0;
        w_send_idle = 1'b0;
        if (!channel_up) begin
            w_send_idle = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_tx_ready  = tx_valid & ~tx_sof;
                    w_send_idle = ~(tx_valid & tx_sof);
                end
                ST_DATA: begin
                    w_tx_ready  = 1'b1;
                    w_send_idle = ~tx_valid;
                end
                default: begin
                    w_tx_ready  = 1'b0;
                    w_send_idle = 1'b0;
                end
            endcase
        end
    end

    assign w_accept = tx_valid & w_tx_ready;

    // Next symbol, error pulse and state; the SOF byte is held until DATA actually takes it.
    always_comb begin
        w_sym        = idle_symbol(send_A, send_R, send_K);
        w_is_k       = 1'b1;
        w_err        = 1'b0;
        w_next_state = r_state;
        w_first_next = r_first;
        if (!channel_up) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (tx_valid && tx_sof) begin
                        w_sym        = K28_2;
                        w_next_state = ST_SCP2;
                    end else begin
                        w_err = tx_valid;
                    end
                end
                ST_SCP2: begin
                    w_sym        = K27_7;
                    w_next_state = ST_DATA;
                    w_first_next = 1'b1;
                end
                ST_DATA: begin
                    if (w_accept) begin
                        w_sym        = tx_data;
                        w_is_k       = 1'b0;
                        w_first_next = 1'b0;
                        w_err        = tx_sof & ~r_first;
                        if (tx_eof) begin
                            w_next_state = ST_ECP1;
                        end else begin
                            w_next_state = ST_DATA;
                        end
                    end else begin
                        w_next_state = ST_DATA;
                    end
                end
                ST_ECP1: begin
                    w_sym        = K29_7;
                    w_next_state = ST_ECP2;
                end
                ST_ECP2: begin
                    w_sym        = K30_7;
                    w_next_state = ST_IDLE;
                end
                default: begin
                    w_next_state = ST_IDLE;
                end
            endcase
        end
    end

    // State and registered encoder-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_first        <= 1'b0;
            r_enc_data     <= K28_5;
            r_enc_is_k     <= 1'b1;
            r_protocol_err <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_first        <= w_first_next;
            r_enc_data     <= w_sym;
            r_enc_is_k     <= w_is_k;
            r_protocol_err <= w_err;
        end
    end

    assign tx_ready     = w_tx_ready;
    assign send_idle    = w_send_idle;
    assign enc_data     = r_enc_data;
    assign enc_is_k     = r_enc_is_k;
    assign protocol_err = r_protocol_err;

endmodule

// File: tb/tb_tx_lane_symbol_gen.sv
// Bench for tx_lane_symbol_gen: directed vector table, corner sequences, randomized frames.
module tb_tx_lane_symbol_gen;

    typedef struct {
        logic       cu;
        logic       v;
        logic       sof;
        logic       eof;
        logic [7:0] d;
        logic       fk;
        logic       fa;
        logic       fr;
        logic       x_ready;
        logic       x_idle;
        logic [7:0] x_data;
        logic       x_k;
        logic       x_err;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       channel_up;
    logic [7:0] tx_data;
    logic       tx_valid, tx_sof, tx_eof;
    logic       tx_ready, send_idle;
    logic       send_K, send_A, send_R;
    logic [7:0] enc_data;
    logic       enc_is_k, protocol_err;

    int total = 0;
    int bad   = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    tx_lane_symbol_gen dut (
        .clk(clk), .rst_n(rst_n), .channel_up(channel_up),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_sof(tx_sof), .tx_eof(tx_eof),
        .tx_ready(tx_ready), .send_idle(send_idle),
        .send_K(send_K), .send_A(send_A), .send_R(send_R),
        .enc_data(enc_data), .enc_is_k(enc_is_k), .protocol_err(protocol_err)
    );

    // Idle symbol the link should carry for a given set of idle-generator flags.
    function automatic logic [7:0] idle_of(input logic a, input logic r);
        if (a) return 8'h7C;
        if (r) return 8'h1C;
        return 8'hBC;
    endfunction

    function automatic vec_t mk(input logic cu, v, sof, eof, input logic [7:0] d,
                                input logic fk, fa, fr, x_ready, x_idle,
                                input logic [7:0] x_data, input logic x_k, x_err);
        vec_t t;
        t.cu = cu; t.v = v; t.sof = sof; t.eof = eof; t.d = d;
        t.fk = fk; t.fa = fa; t.fr = fr;
        t.x_ready = x_ready; t.x_idle = x_idle; t.x_data = x_data; t.x_k = x_k; t.x_err = x_err;
        return t;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // One lane cycle: drive, check combinational handshake, clock, check registered symbol.
    task automatic step(input vec_t t, input string tag);
        @(negedge clk);
        channel_up = t.cu; tx_valid = t.v; tx_sof = t.sof; tx_eof = t.eof; tx_data = t.d;
        send_K = t.fk; send_A = t.fa; send_R = t.fr;
        #1;
        chk({tag, ".tx_ready"}, {7'd0, tx_ready}, {7'd0, t.x_ready});
        chk({tag, ".send_idle"}, {7'd0, send_idle}, {7'd0, t.x_idle});
        @(posedge clk);
        #1;
        chk({tag, ".enc_data"}, enc_data, t.x_data);
        chk({tag, ".enc_is_k"}, {7'd0, enc_is_k}, {7'd0, t.x_k});
        chk({tag, ".protocol_err"}, {7'd0, protocol_err}, {7'd0, t.x_err});
    endtask

    task automatic idle_step(input logic cu, input logic v, input logic x_ready, input string tag);
        logic fk, fa, fr;
        fk = 1'($urandom); fa = 1'($urandom); fr = 1'($urandom);
        step(mk(cu, v, 1'b0, 1'b0, 8'($urandom), fk, fa, fr, x_ready, 1'b1,
                idle_of(fa, fr), 1'b1, 1'b0), tag);
    endtask

    initial begin
        logic [7:0] b;
        int n, gap;
        rst_n = 1'b1; channel_up = 1'b1; tx_valid = 1'b0; tx_sof = 1'b0; tx_eof = 1'b0;
        tx_data = 8'h00; send_K = 1'b0; send_A = 1'b0; send_R = 1'b0;
        #2 rst_n = 1'b0;
        #5;
        chk("reset.enc_data", enc_data, 8'hBC);
        chk("reset.enc_is_k", {7'd0, enc_is_k}, 8'd1);
        chk("reset.protocol_err", {7'd0, protocol_err}, 8'd0);
        @(negedge clk); rst_n = 1'b1;

        //             cu  v  sof eof data   k  a  r  rdy idl  exp    k  err
        tbl.push_back(mk(1, 0, 0, 0, 8'h00, 1, 0, 0, 0, 1, 8'hBC, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 8'h00, 0, 1, 0, 0, 1, 8'h7C, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 8'h00, 0, 0, 1, 0, 1, 8'h1C, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 8'h00, 0, 1, 1, 0, 1, 8'h7C, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 1, 8'hBC, 1, 0));
        tbl.push_back(mk(1, 1, 1, 0, 8'h11, 1, 0, 0, 0, 0, 8'h5C, 1, 0));
        tbl.push_back(mk(1, 1, 1, 0, 8'h11, 1, 0, 0, 0, 0, 8'hFB, 1, 0));
        tbl.push_back(mk(1, 1, 1, 0, 8'h11, 1, 0, 0, 1, 0, 8'h11, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 8'h22, 1, 0, 0, 1, 0, 8'h22, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 8'h99, 0, 0, 1, 1, 1, 8'h1C, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 8'h99, 1, 0, 0, 1, 1, 8'hBC, 1, 0));
        tbl.push_back(mk(1, 1, 0, 1, 8'h33, 1, 0, 0, 1, 0, 8'h33, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 8'hFD, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 8'hFE, 1, 0));
        tbl.push_back(mk(1, 1, 0, 0, 8'h55, 1, 0, 0, 1, 1, 8'hBC, 1, 1));
        tbl.push_back(mk(1, 0, 0, 0, 8'h00, 0, 1, 0, 0, 1, 8'h7C, 1, 0));
        tbl.push_back(mk(1, 1, 1, 1, 8'hAA, 1, 0, 0, 0, 0, 8'h5C, 1, 0));
        tbl.push_back(mk(1, 1, 1, 1, 8'hAA, 1, 0, 0, 0, 0, 8'hFB, 1, 0));
        tbl.push_back(mk(1, 1, 1, 1, 8'hAA, 1, 0, 0, 1, 0, 8'hAA, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 8'h01, 1, 0, 0, 0, 0, 8'hFD, 1, 0));
        tbl.push_back(mk(1, 1, 1, 0, 8'h01, 1, 0, 0, 0, 0, 8'hFE, 1, 0));
        tbl.push_back(mk(1, 1, 1, 0, 8'h01, 1, 0, 0, 0, 0, 8'h5C, 1, 0));
        tbl.push_back(mk(1, 1, 1, 0, 8'h01, 1, 0, 0, 0, 0, 8'hFB, 1, 0));
        tbl.push_back(mk(1, 1, 1, 0, 8'h01, 1, 0, 0, 1, 0, 8'h01, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 8'h02, 1, 0, 0, 1, 0, 8'h02, 0, 1));
        tbl.push_back(mk(1, 1, 0, 1, 8'h03, 1, 0, 0, 1, 0, 8'h03, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 8'hFD, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 8'hFE, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 8'h00, 1, 0, 0, 0, 1, 8'hBC, 1, 0));
        for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("vec%0d", i));

        // channel_up falls in DATA: frame aborted without ECP or error.
        step(mk(1, 1, 1, 0, 8'h44, 1, 0, 0, 0, 0, 8'h5C, 1, 0), "drop.scp1");
        step(mk(1, 1, 1, 0, 8'h44, 1, 0, 0, 0, 0, 8'hFB, 1, 0), "drop.scp2");
        step(mk(1, 1, 1, 0, 8'h44, 1, 0, 0, 1, 0, 8'h44, 0, 0), "drop.d0");
        step(mk(0, 1, 0, 0, 8'h45, 0, 0, 1, 0, 1, 8'h1C, 1, 0), "drop.down");
        step(mk(1, 1, 0, 1, 8'h46, 1, 0, 0, 1, 1, 8'hBC, 1, 1), "drop.after");
        step(mk(1, 0, 0, 0, 8'h00, 1, 0, 0, 0, 1, 8'hBC, 1, 0), "drop.idle");

        // Reset asserted mid-frame: outputs snap back without a clock edge.
        step(mk(1, 1, 1, 0, 8'h50, 1, 0, 0, 0, 0, 8'h5C, 1, 0), "rst.scp1");
        step(mk(1, 1, 1, 0, 8'h50, 1, 0, 0, 0, 0, 8'hFB, 1, 0), "rst.scp2");
        step(mk(1, 1, 1, 0, 8'h50, 1, 0, 0, 1, 0, 8'h50, 0, 0), "rst.d0");
        @(negedge clk); rst_n = 1'b0; tx_valid = 1'b0;
        #1;
        chk("rst.mid.enc_data", enc_data, 8'hBC);
        chk("rst.mid.enc_is_k", {7'd0, enc_is_k}, 8'd1);
        chk("rst.mid.protocol_err", {7'd0, protocol_err}, 8'd0);
        @(negedge clk); rst_n = 1'b1;
        step(mk(1, 0, 0, 0, 8'h00, 1, 0, 0, 0, 1, 8'hBC, 1, 0), "rst.after");

        // Randomized well-formed frames; expected stream built from the framing rules.
        for (int f = 0; f < 40; f++) begin
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) idle_step(1'b1, 1'b0, 1'b0, "rnd.gap");
            n = $urandom_range(1, 5);
            b = 8'($urandom);
            step(mk(1, 1, 1, n == 1, b, 1, 0, 0, 0, 0, 8'h5C, 1, 0), "rnd.scp1");
            step(mk(1, 1, 1, n == 1, b, 1, 0, 0, 0, 0, 8'hFB, 1, 0), "rnd.scp2");
            step(mk(1, 1, 1, n == 1, b, 1, 0, 0, 1, 0, b, 0, 0), "rnd.d0");
            for (int i = 1; i < n; i++) begin
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) idle_step(1'b1, 1'b0, 1'b1, "rnd.ingap");
                b = 8'($urandom);
                step(mk(1, 1, 0, i == n - 1, b, 0, 0, 0, 1, 0, b, 0, 0), "rnd.d");
            end
            step(mk(1, 0, 0, 0, 8'h00, 0, 1, 1, 0, 0, 8'hFD, 1, 0), "rnd.ecp1");
            step(mk(1, 0, 0, 0, 8'h00, 0, 1, 1, 0, 0, 8'hFE, 1, 0), "rnd.ecp2");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
